// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular buffer of {PC, instr} pairs
// between fetch and decode, updated on the falling edge of Clk.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          Flush,
   input  logic          InValid,
   input  logic [31:0]   InPC,
   input  logic [31:0]   InInstr,
   output logic          InReady,
   output logic          OutValid,
   output logic [31:0]   OutPC,
   output logic [31:0]   OutInstr,
   input  logic          OutReady,
   output logic [AW:0]   Count
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     cnt;
   logic            push, pop;

   // Ready/valid come only from the registered count, so neither side
   // sees a combinational path from the other.
   assign InReady  = (cnt != FULL);
   assign OutValid = (cnt != '0);
   assign push     = InValid & InReady;
   assign pop      = OutValid & OutReady;
   assign Count    = cnt;
   assign OutPC    = mem[rd_ptr].pc;
   assign OutInstr = mem[rd_ptr].instr;

   always_ff @(negedge Clk or posedge Rst) begin
      if (Rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (Flush) begin
         // Redirect drops everything; stale storage is simply overwritten later.
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{pc: InPC, instr: InInstr};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule
